// File: rtl/seg7_scan_driver_if.sv
// Bus between a display controller and the 7-segment scan driver:
// digit data and display controls in, segment and digit strobes out.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                lt;
    logic                bi;
    logic                rbi;
    logic                a, b, c, d, e, f, g;
    logic [DIGITS-1:0]   digit_en;
    logic                frame_start;

    modport master (
        output value, load, lt, bi, rbi,
        input  a, b, c, d, e, f, g, digit_en, frame_start
    );

    modport slave (
        input  value, load, lt, bi, rbi,
        output a, b, c, d, e, f, g, digit_en, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver: shadow register, prescaled digit scan,
// BCD/hex decode, lamp test, blanking and leading-zero suppression.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int HEX_MODE = 0
) (
    input logic              clk,
    input logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNTW = $clog2(SCAN_DIV);

    logic [CNTW-1:0]     cnt;
    logic [IDXW-1:0]     idx;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   en;
    logic                fs;

    logic                lastCnt;
    logic                lastIdx;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   supp;
    logic                allZero;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
            4'hB: s = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
            4'hC: s = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
            4'hD: s = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
            4'hE: s = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
            default: s = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
        endcase
        return s;
    endfunction

    assign lastCnt = (cnt == CNTW'(SCAN_DIV - 1));
    assign lastIdx = (idx == IDXW'(DIGITS - 1));

    // A digit is blank when it and every more significant nibble are zero;
    // digit 0 always shows so a zero value still displays "0".
    always_comb begin
        nib     = shadow[4*idx +: 4];
        supp    = '0;
        allZero = bus.rbi;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allZero = allZero && (shadow[4*i +: 4] == 4'd0);
            supp[i] = (i != 0) && allZero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            seg     <= 7'b0000000;
            en      <= '0;
            fs      <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow <= bus.value;
            end
            if (lastCnt) begin
                cnt <= '0;
                idx <= lastIdx ? '0 : idx + IDXW'(1);
            end else begin
                cnt <= cnt + CNTW'(1);
            end
            // pending marks the first cycle back on digit 0 so the strobe
            // lines up with the registered digit_en for that digit.
            pending <= lastCnt && lastIdx;
            fs      <= pending;
            en      <= bus.bi ? '0 : (DIGITS'(1) << idx);
            if (bus.bi) begin
                seg <= 7'b0000000;
            end else if (bus.lt) begin
                seg <= 7'b1111111;
            end else if (supp[idx]) begin
                seg <= 7'b0000000;
            end else begin
                seg <= decode(nib);
            end
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg;
    assign bus.digit_en    = en;
    assign bus.frame_start = fs;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: BCD and hex instances driven in
// lockstep against a behavioural model of the scan and decode.
module tb_seg7_scan_driver;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] BCDTAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };
    localparam logic [6:0] HEXTAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic [6:0] segB;
        logic [6:0] segH;
        logic [3:0] en;
        logic       fs;
    } expT;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    int          mCnt;
    int          mIdx;
    int          mPrevIdx;
    logic [15:0] mShadow;
    expT         sbq[$];

    seg7_scan_driver_if #(.DIGITS(DIGITS)) busB ();
    seg7_scan_driver_if #(.DIGITS(DIGITS)) busH ();

    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_MODE(0)) dutB (
        .clk(clk), .reset(reset), .bus(busB.slave)
    );
    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_MODE(1)) dutH (
        .clk(clk), .reset(reset), .bus(busH.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, predicts the outputs registered at the
    // coming edge, then compares them just after that edge.
    task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] val,
                                 input logic ltIn, input logic biIn, input logic rbiIn);
        expT        e;
        expT        got;
        logic [3:0] nib;
        logic       supp;
        reset      = rst;
        busB.load  = ld;   busH.load  = ld;
        busB.value = val;  busH.value = val;
        busB.lt    = ltIn; busH.lt    = ltIn;
        busB.bi    = biIn; busH.bi    = biIn;
        busB.rbi   = rbiIn; busH.rbi  = rbiIn;

        if (rst) begin
            e        = '0;
            mCnt     = 0;
            mIdx     = 0;
            mPrevIdx = 0;
            mShadow  = 16'h0;
        end else begin
            nib  = mShadow[mIdx*4 +: 4];
            supp = rbiIn && (mIdx != 0) && ((mShadow >> (4 * mIdx)) == 16'h0);
            if (biIn) begin
                e.segB = 7'b0; e.segH = 7'b0;
            end else if (ltIn) begin
                e.segB = 7'b1111111; e.segH = 7'b1111111;
            end else if (supp) begin
                e.segB = 7'b0; e.segH = 7'b0;
            end else begin
                e.segB = BCDTAB[nib]; e.segH = HEXTAB[nib];
            end
            e.en = biIn ? 4'b0000 : 4'(1 << mIdx);
            e.fs = (mIdx == 0) && (mPrevIdx == DIGITS - 1);
            if (ld) mShadow = val;
            mPrevIdx = mIdx;
            if (mCnt == SCAN_DIV - 1) begin
                mCnt = 0;
                mIdx = (mIdx + 1) % DIGITS;
            end else begin
                mCnt = mCnt + 1;
            end
        end
        sbq.push_back(e);

        @(posedge clk);
        #1;
        got = sbq.pop_front();
        checkOutput("segBcd", {25'b0, busB.a, busB.b, busB.c, busB.d, busB.e, busB.f, busB.g}, {25'b0, got.segB});
        checkOutput("segHex", {25'b0, busH.a, busH.b, busH.c, busH.d, busH.e, busH.f, busH.g}, {25'b0, got.segH});
        checkOutput("enBcd", {28'b0, busB.digit_en}, {28'b0, got.en});
        checkOutput("enHex", {28'b0, busH.digit_en}, {28'b0, got.en});
        checkOutput("fsBcd", {31'b0, busB.frame_start}, {31'b0, got.fs});
        checkOutput("fsHex", {31'b0, busH.frame_start}, {31'b0, got.fs});
    endtask

    task automatic runCycles(input int n, input logic ltIn, input logic biIn, input logic rbiIn);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, ltIn, biIn, rbiIn);
    endtask

    initial begin
        int guard;
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("resetEn", {28'b0, busB.digit_en}, 32'h0);

        // Release with a load: first output still shows the cleared shadow.
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        checkOutput("firstEn", {28'b0, busB.digit_en}, 32'h1);
        checkOutput("firstSeg", {25'b0, busB.a, busB.b, busB.c, busB.d, busB.e, busB.f, busB.g}, 32'h7E);
        runCycles(20, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 1'b1);
        runCycles(16, 1'b0, 1'b0, 1'b1);
        runCycles(16, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'hABCF, 1'b0, 1'b0, 1'b0);
        runCycles(16, 1'b0, 1'b0, 1'b0);

        runCycles(8, 1'b1, 1'b0, 1'b0);
        runCycles(4, 1'b1, 1'b1, 1'b0);
        runCycles(4, 1'b0, 1'b0, 1'b0);

        // Load exactly on the cycle the scan moves from digit 1 to digit 2.
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (!(mIdx == 1 && mCnt == SCAN_DIV - 1) && guard < 32) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        checkOutput("advGuard", (guard < 32) ? 32'h1 : 32'h0, 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h1734, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("advEn", {28'b0, busB.digit_en}, 32'h4);
        checkOutput("advSeg", {25'b0, busB.a, busB.b, busB.c, busB.d, busB.e, busB.f, busB.g}, 32'h70);
        runCycles(8, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of digit 2.
        guard = 0;
        while (mIdx != 2 && guard < 32) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("midRstEn", {28'b0, busB.digit_en}, 32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("relEn", {28'b0, busB.digit_en}, 32'h1);
        checkOutput("relSeg", {25'b0, busB.a, busB.b, busB.c, busB.d, busB.e, busB.f, busB.g}, 32'h7E);
        runCycles(20, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 5) == 0), 16'($urandom),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
